// File: rtl/sweep_pkg.sv
// Shared types and sizes for the truth-table sweeper: FSM states and
// vector/counter widths used by the sweeper, its timer and its interface.
package sweep_pkg;
  localparam int N_VEC = 16;
  localparam int IDX_W = 4;
  localparam int CNT_W = 8;
  localparam int ERR_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;
endpackage

// File: rtl/truth_table_sweeper_if.sv
// Stimulus/capture bundle between the sweeper and whoever starts it and
// owns the circuit under drive.
interface truth_table_sweeper_if;
  import sweep_pkg::*;

  logic             start;
  logic [N_VEC-1:0] expected;
  logic             dut_w;
  logic [IDX_W-1:0] abcd;
  logic             busy;
  logic             done;
  logic [N_VEC-1:0] truth_tbl;
  logic [ERR_W-1:0] err_count;
  logic             mismatch;
  logic             unknown;

  modport master (
    output start, expected, dut_w,
    input  abcd, busy, done, truth_tbl, err_count, mismatch, unknown
  );

  modport slave (
    input  start, expected, dut_w,
    output abcd, busy, done, truth_tbl, err_count, mismatch, unknown
  );
endinterface

// File: rtl/settle_timer.sv
// Loadable down-counter that stops at zero; zero flags the end of a
// settle window.
module settle_timer
  import sweep_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks abcd through all input vectors, lets each settle, samples dut_w and
// scores the captured truth table against the expected one.
module truth_table_sweeper
  import sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int N_IN          = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  truth_table_sweeper_if.slave sif
);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'((1 << N_IN) - 1);
  localparam logic [CNT_W-1:0] SETTLE_RLD = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state;
  logic [IDX_W-1:0] abcd_q;
  logic             busy_q;
  logic             done_q;
  logic [N_VEC-1:0] tbl_q;
  logic [ERR_W-1:0] err_q;
  logic             mism_q;
  logic             unk_q;

  logic             tmr_load;
  logic             tmr_zero;
  logic             w_unk;
  logic             w_bit;
  logic [ERR_W-1:0] err_next;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] e);
    return (e >= ERR_W'(N_VEC)) ? e : e + ERR_W'(1);
  endfunction

  // Timer is armed on sweep start and on every advance to the next vector.
  assign tmr_load = (((state == IDLE) || (state == DONE)) && sif.start) ||
                    ((state == SAMPLE) && (abcd_q != LAST_IDX));

  settle_timer u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (SETTLE_RLD),
    .zero     (tmr_zero)
  );

  // X/Z detection is a 4-state check: meaningful in simulation only, it
  // reduces to "never unknown" in hardware and in 2-state simulators.
  always_comb begin
    w_unk    = $isunknown(sif.dut_w);
    w_bit    = w_unk ? 1'b0 : sif.dut_w;
    err_next = (w_bit != sif.expected[abcd_q]) ? sat_inc(err_q) : err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      abcd_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      tbl_q  <= '0;
      err_q  <= '0;
      mism_q <= 1'b0;
      unk_q  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (sif.start) begin
            tbl_q  <= '0;
            err_q  <= '0;
            mism_q <= 1'b0;
            unk_q  <= 1'b0;
            done_q <= 1'b0;
            abcd_q <= '0;
            busy_q <= 1'b1;
            state  <= SETTLE;
          end
        end
        SETTLE: begin
          if (tmr_zero) state <= SAMPLE;
        end
        SAMPLE: begin
          tbl_q[abcd_q] <= w_bit;
          if (w_unk) unk_q <= 1'b1;
          err_q  <= err_next;
          mism_q <= (err_next != '0);
          // abcd only moves here, so it is stable for the whole settle window.
          if (abcd_q != LAST_IDX) begin
            abcd_q <= abcd_q + IDX_W'(1);
            state  <= SETTLE;
          end else begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sif.abcd      = abcd_q;
  assign sif.busy      = busy_q;
  assign sif.done      = done_q;
  assign sif.truth_tbl = tbl_q;
  assign sif.err_count = err_q;
  assign sif.mismatch  = mism_q;
  assign sif.unknown   = unk_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: directed scenarios plus randomized 4-state
// circuit tables, scored against a truth-table model.
module tb_truth_table_sweeper;
  import sweep_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  truth_table_sweeper_if ifa ();
  truth_table_sweeper_if ifb ();

  truth_table_sweeper #(.SETTLE_CYCLES(4), .N_IN(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .sif (ifa.slave)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(1), .N_IN(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .sif (ifb.slave)
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  int          mode;
  logic [15:0] w_map;
  logic [2:0]  sr_a;
  logic [2:0]  sr_b;

  // Inverter on input a whose output lags its input by three clock cycles.
  always @(posedge clk) begin
    sr_a <= {sr_a[1:0], ifa.abcd[3]};
    sr_b <= {sr_b[1:0], ifb.abcd[3]};
  end

  assign ifa.dut_w = (mode == 0) ? ifa.abcd[0] :
                     (mode == 1) ? w_map[ifa.abcd] : ~sr_a[2];
  assign ifb.dut_w = ~sr_b[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Settled circuit truth table -> captured table, error count, unknown flag.
  function automatic void model(input logic [15:0] map_v, input logic [15:0] exp_v,
                                output logic [15:0] t, output int e, output logic u);
    logic b;
    t = '0;
    u = 1'b0;
    for (int i = 0; i < 16; i++) begin
      b = map_v[i];
      if ($isunknown(b)) u = 1'b1;
      else               t[i] = b;
    end
    e = $countones(t ^ exp_v);
  endfunction

  task automatic chk_a_zero(input string tag);
    chk(tag, 32'({ifa.abcd, ifa.busy, ifa.done, ifa.truth_tbl, ifa.err_count,
                  ifa.mismatch, ifa.unknown}), 32'd0);
  endtask

  task automatic sweep_a(input int pulse_idx, output int edges);
    bit             pulsed = 1'b0;
    bit             seq_ok = 1'b1;
    logic [3:0]     prev;
    @(negedge clk);
    ifa.start = 1'b1;
    @(posedge clk);
    #1 ifa.start = 1'b0;
    chk("start_clears", 32'({ifa.busy, ifa.done, ifa.truth_tbl, ifa.err_count,
                             ifa.mismatch, ifa.unknown, ifa.abcd}), 32'h1000_0000);
    prev  = ifa.abcd;
    edges = 0;
    while (edges < 400) begin
      @(posedge clk);
      edges++;
      #1;
      if (ifa.abcd != prev) begin
        if (ifa.abcd != prev + 4'd1) seq_ok = 1'b0;
        prev = ifa.abcd;
      end
      if (ifa.done === 1'b1) break;
      if (pulse_idx >= 0 && !pulsed && ifa.abcd == pulse_idx[3:0]) begin
        ifa.start = 1'b1;
        pulsed    = 1'b1;
      end else begin
        ifa.start = 1'b0;
      end
    end
    ifa.start = 1'b0;
    chk("abcd_seq", 32'(seq_ok), 32'd1);
  endtask

  task automatic check_a(input string tag, input logic [15:0] map_v,
                         input logic [15:0] exp_v, input int edges);
    logic [15:0] t;
    int          e;
    logic        u;
    model(map_v, exp_v, t, e, u);
    chk({tag, "_lat"},  32'(edges), 32'd80);
    chk({tag, "_tbl"},  32'(ifa.truth_tbl), 32'(t));
    chk({tag, "_err"},  32'(ifa.err_count), 32'(e));
    chk({tag, "_mism"}, 32'(ifa.mismatch), 32'(e != 0));
    chk({tag, "_unk"},  32'(ifa.unknown), 32'(u));
    repeat (3) @(posedge clk);
    #1 chk({tag, "_hold"}, 32'({ifa.done, ifa.busy, ifa.abcd, ifa.truth_tbl}),
           32'({1'b1, 1'b0, 4'hF, t}));
  endtask

  initial begin
    int          edges;
    int          k;
    logic [15:0] exp_v;
    logic [15:0] t;
    int          e;
    logic        u;

    rst          = 1'b1;
    mode         = 0;
    w_map        = '0;
    ifa.start    = 1'b0;
    ifa.expected = '0;
    ifb.start    = 1'b0;
    ifb.expected = 16'h00FF;
    #12 chk_a_zero("reset_state");
    @(negedge clk);
    rst = 1'b0;

    // dut_w = d, matching expected table
    mode = 0; ifa.expected = 16'hAAAA;
    sweep_a(-1, edges);
    check_a("d_match", 16'hAAAA, 16'hAAAA, edges);

    // one-bit disagreement in the expected table
    ifa.expected = 16'hAAAB;
    sweep_a(-1, edges);
    check_a("d_1err", 16'hAAAA, 16'hAAAB, edges);

    // floating output on every vector
    mode = 1; w_map = 16'bz; ifa.expected = 16'h0000;
    sweep_a(-1, edges);
    check_a("all_z", w_map, 16'h0000, edges);

    // start pulsed mid-sweep must be ignored
    mode = 0; ifa.expected = 16'hAAAA;
    sweep_a(7, edges);
    check_a("mid_start", 16'hAAAA, 16'hAAAA, edges);

    // delayed inverter on a, with enough settle time
    mode = 2; ifa.expected = 16'h00FF;
    sweep_a(-1, edges);
    check_a("inv_s4", 16'h00FF, 16'h00FF, edges);

    // asynchronous reset in the middle of a sweep
    mode = 0; ifa.expected = 16'hAAAA;
    @(negedge clk);
    ifa.start = 1'b1;
    @(posedge clk);
    #1 ifa.start = 1'b0;
    k = 0;
    while (ifa.abcd != 4'd7 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("reach_idx7", 32'(ifa.abcd), 32'd7);
    #3 rst = 1'b1;
    #1 chk_a_zero("async_rst");
    @(negedge clk);
    chk_a_zero("rst_held");
    rst = 1'b0;
    sweep_a(-1, edges);
    check_a("post_rst", 16'hAAAA, 16'hAAAA, edges);

    // randomized 4-state circuit tables
    mode = 1;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 16; i++) begin
        case ($urandom_range(0, 7))
          0:       w_map[i] = 1'bx;
          1:       w_map[i] = 1'bz;
          default: w_map[i] = 1'($urandom_range(0, 1));
        endcase
      end
      if (it[0]) begin
        model(w_map, 16'h0000, t, e, u);
        exp_v = t ^ ((it == 3) ? 16'h0000 : 16'(1 << $urandom_range(0, 15)));
      end else begin
        exp_v = 16'($urandom);
      end
      ifa.expected = exp_v;
      sweep_a(-1, edges);
      check_a($sformatf("rnd%0d", it), w_map, exp_v, edges);
    end

    // short settle against the slow inverter
    @(negedge clk);
    ifb.start = 1'b1;
    @(posedge clk);
    #1 ifb.start = 1'b0;
    edges = 0;
    while (edges < 200) begin
      @(posedge clk);
      edges++;
      #1;
      if (ifb.done === 1'b1) break;
    end
    chk("inv_s1_lat", 32'(edges), 32'd32);
    chk("inv_s1_errs", 32'(ifb.err_count != 5'd0), 32'd1);
    chk("inv_s1_mism", 32'(ifb.mismatch), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Sequential stimulus/capture stage wrapped around one of our 4-input, 1-output switch-level circuits.
- Drives the circuit's a,b,c,d inputs through all 16 combinations.
- Waits a programmable settle time so the transistor-delay paths can resolve, then samples the output w.
- Builds a 16-bit truth table, compares it against an expected table, and reports mismatches and X/Z outputs.

Parameters:
SETTLE_CYCLES, 4, clock cycles abcd is held stable before w is sampled; legal range 1..255
N_IN, 4, number of circuit inputs; fixed at 4, giving N_VEC = 16 vectors

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  sweep request, sampled on a rising edge of clk
expected  input  16  golden truth table; bit i = expected w for abcd == i
dut_w  input  1  output of the circuit under drive (combinational, may be X/Z)
abcd  output  4  registered stimulus; abcd[3]=a, abcd[2]=b, abcd[1]=c, abcd[0]=d
busy  output  1  high while a sweep is running
done  output  1  high from sweep completion until the next accepted start or reset
table  output  16  captured truth table; bit i = sampled w for abcd == i
err_count  output  5  number of bits where table != expected (0..16)
mismatch  output  1  (err_count != 0), valid while done
unknown  output  1  set if any sample of dut_w was X or Z

Behaviour:
- Reset is asynchronous and active-high. On reset, all outputs go to 0 immediately: abcd=0, busy=0, done=0, table=0, err_count=0, mismatch=0, unknown=0. The FSM goes to IDLE and the settle counter goes to 0.
- FSM states are IDLE, SETTLE, SAMPLE, DONE.
- IDLE or DONE with start=1: clear table, err_count, mismatch, unknown and done; set abcd=0 and busy=1; load settle counter = SETTLE_CYCLES-1; go to SETTLE.
- start in SETTLE or SAMPLE is ignored and has no side effects.
- SETTLE: decrement the counter each cycle. When counter == 0, go to SAMPLE. abcd is unchanged throughout.
- SAMPLE (one cycle), with idx = abcd:
  - Write table[idx] = dut_w.
  - If dut_w is X or Z, write table[idx] = 0 and set unknown.
  - If the stored bit differs from expected[idx], err_count += 1. The count is saturating but cannot exceed 16.
  - If idx != 15: abcd = idx+1 (4-bit), reload counter, go to SETTLE.
  - If idx == 15: busy=0, done=1, abcd holds 15, go to DONE.
- Latency: each vector occupies SETTLE_CYCLES+1 cycles. With start sampled at edge E0, done=1 after edge E0 + 16*(SETTLE_CYCLES+1); 80 edges with the default.
- abcd changes only on the edge leaving SAMPLE, so it is glitch-free and stable for the whole settle window.
- expected is sampled only in SAMPLE and may change between vectors. Benches hold it constant.
- mismatch is combinational from err_count and registered alongside it.
- DONE: outputs hold. table, err_count and unknown remain readable until the next start.
- Reset mid-sweep: immediate return to the reset values. No partial table is retained.
- Simultaneous rst and start: rst wins.

Decomposition:
- Shared package sweep_pkg: state enum (IDLE, SETTLE, SAMPLE, DONE), N_VEC=16, IDX_W=4, CNT_W=8.
- One sub-module, settle_timer. It is a loadable down-counter with ports clk, rst, load, load_val, zero. The FSM instantiates it.
- X/Z detection uses a 4-state comparison of dut_w; this is simulation-only semantics and is documented as such.

Test Plan:
- dut_w tied to abcd[0], expected=16'hAAAA, SETTLE=4 → table=16'hAAAA, err_count=0, mismatch=0, done rises 80 edges after start.
- Same stimulus, expected=16'hAAAB → err_count=1, mismatch=1, table=16'hAAAA.
- dut_w = 1'bz for all vectors, expected=0 → unknown=1, table=0, err_count=0.
- Pulse start again at vector 7 of a sweep → ignored: abcd continues 8..15, single done.
- Assert rst while abcd=7, not aligned to clk → all outputs 0 at once; a new start gives a full 16-vector sweep.
- Inverter model on abcd[3] with 3-cycle delay, SETTLE=4 → table=16'h00FF, no errors. Same model with SETTLE=1 → err_count>0.
